// File: rtl/fc_rx_credit_allocator.sv
// Receive-side flow-control credit allocator: tracks allocated/received credits per type and
// emits InitFC then UpdateFC DLLPs. Optional periodic refresh is enabled by FC_UPDATE_TIMER_EN.
module fc_rx_credit_allocator #(
    parameter int INIT_PH       = 32,
    parameter int INIT_PD       = 256,
    parameter int INIT_NPH      = 32,
    parameter int INIT_CPLH     = 64,
    parameter int INIT_CPLD     = 512,
    parameter int UPDATE_PERIOD = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init_fc_start_i,
    input  logic        rx_tlp_valid_i,
    input  logic [1:0]  rx_tlp_type_i,
    input  logic [7:0]  rx_hdr_credit_i,
    input  logic [11:0] rx_data_credit_i,
    input  logic        free_valid_i,
    input  logic [1:0]  free_type_i,
    input  logic [7:0]  free_hdr_credit_i,
    input  logic [11:0] free_data_credit_i,
    output logic        dllp_valid_o,
    input  logic        dllp_ready_i,
    output logic        dllp_is_init_o,
    output logic [1:0]  dllp_fc_type_o,
    output logic [7:0]  dllp_hdr_fc_o,
    output logic [11:0] dllp_data_fc_o,
    output logic        fc_init_done_o,
    output logic        overflow_err_o
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_INIT = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] T_P     = 2'd0;
    localparam logic [1:0] T_NP    = 2'd1;
    localparam logic [1:0] T_CPL   = 2'd2;

    localparam logic [7:0]  INIT_PH_C   = 8'(INIT_PH);
    localparam logic [11:0] INIT_PD_C   = 12'(INIT_PD);
    localparam logic [7:0]  INIT_NPH_C  = 8'(INIT_NPH);
    localparam logic [7:0]  INIT_CPLH_C = 8'(INIT_CPLH);
    localparam logic [11:0] INIT_CPLD_C = 12'(INIT_CPLD);

    // A receiver has overflowed when allocated - received lands in the upper half of the field.
    function automatic logic over8(input logic [7:0] alloc, input logic [7:0] rcvd);
        logic [7:0] diff;
        diff = alloc - rcvd;
        return diff[7];
    endfunction

    function automatic logic over12(input logic [11:0] alloc, input logic [11:0] rcvd);
        logic [11:0] diff;
        diff = alloc - rcvd;
        return diff[11];
    endfunction

    logic [1:0]  state_q, state_d;
    logic [7:0]  alloc_ph_q, alloc_ph_d, alloc_nph_q, alloc_nph_d, alloc_cplh_q, alloc_cplh_d;
    logic [11:0] alloc_pd_q, alloc_pd_d, alloc_cpld_q, alloc_cpld_d;
    logic [7:0]  rcv_ph_q, rcv_ph_d, rcv_nph_q, rcv_nph_d, rcv_cplh_q, rcv_cplh_d;
    logic [11:0] rcv_pd_q, rcv_pd_d, rcv_cpld_q, rcv_cpld_d;
    logic [2:0]  pend_q, pend_d;
    logic        init_req_q, init_req_d;
    logic        dllp_valid_q, dllp_valid_d, dllp_is_init_q, dllp_is_init_d;
    logic [1:0]  dllp_type_q, dllp_type_d;
    logic [7:0]  dllp_hdr_q, dllp_hdr_d;
    logic [11:0] dllp_data_q, dllp_data_d;
    logic        done_q, done_d, ovf_q, ovf_d;

    logic [2:0]  free_mask_s, launch_mask_s, tmr_mask_s;
    logic [1:0]  launch_type_s;
    logic        hs_s, slot_free_s, enter_init_s, rx_en_s, launch_s;

    // A DLLP handshaking this cycle frees the slot, so launches and INIT entry may follow back-to-back.
    assign hs_s         = dllp_valid_q && dllp_ready_i;
    assign slot_free_s  = !dllp_valid_q || dllp_ready_i;
    assign rx_en_s      = rx_tlp_valid_i && (state_q != ST_IDLE);
    assign enter_init_s = ((state_q == ST_IDLE) && init_fc_start_i) ||
                          ((state_q == ST_RUN) && (init_fc_start_i || init_req_q) && slot_free_s);
    assign launch_s     = (state_q == ST_RUN) && !enter_init_s && slot_free_s && (pend_q != 3'b000);

`ifdef FC_UPDATE_TIMER_EN
    localparam int TMR_W = (UPDATE_PERIOD > 1) ? $clog2(UPDATE_PERIOD) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(UPDATE_PERIOD - 1);
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             tmr_fire_s;

    // Refresh counter, held at zero outside RUN so it restarts on every RUN entry
    always_comb begin
        if (state_q != ST_RUN) begin
            timer_d    = '0;
            tmr_fire_s = 1'b0;
        end else if (timer_q == TMR_LAST) begin
            timer_d    = '0;
            tmr_fire_s = 1'b1;
        end else begin
            timer_d    = timer_q + TMR_W'(1);
            tmr_fire_s = 1'b0;
        end
    end

    // Refresh counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign tmr_mask_s = (tmr_fire_s && !enter_init_s) ? 3'b111 : 3'b000;
`else
    logic unused_period_s;
    assign unused_period_s = (UPDATE_PERIOD != 32'sd0);
    assign tmr_mask_s      = 3'b000;
`endif

    // Free decode and fixed-priority UpdateFC type select (P > NP > Cpl)
    always_comb begin
        case ({free_valid_i, free_type_i})
            3'b100:  free_mask_s = 3'b001;
            3'b101:  free_mask_s = 3'b010;
            3'b110:  free_mask_s = 3'b100;
            default: free_mask_s = 3'b000;
        endcase
        if (pend_q[0]) begin
            launch_type_s = T_P;
        end else if (pend_q[1]) begin
            launch_type_s = T_NP;
        end else begin
            launch_type_s = T_CPL;
        end
        case ({launch_s, launch_type_s})
            3'b100:  launch_mask_s = 3'b001;
            3'b101:  launch_mask_s = 3'b010;
            3'b110:  launch_mask_s = 3'b100;
            default: launch_mask_s = 3'b000;
        endcase
    end

    // Credit counters, overflow detection and pending flags
    always_comb begin
        alloc_ph_d   = enter_init_s ? INIT_PH_C   : alloc_ph_q;
        alloc_pd_d   = enter_init_s ? INIT_PD_C   : alloc_pd_q;
        alloc_nph_d  = enter_init_s ? INIT_NPH_C  : alloc_nph_q;
        alloc_cplh_d = enter_init_s ? INIT_CPLH_C : alloc_cplh_q;
        alloc_cpld_d = enter_init_s ? INIT_CPLD_C : alloc_cpld_q;
        rcv_ph_d     = enter_init_s ? 8'd0  : rcv_ph_q;
        rcv_pd_d     = enter_init_s ? 12'd0 : rcv_pd_q;
        rcv_nph_d    = enter_init_s ? 8'd0  : rcv_nph_q;
        rcv_cplh_d   = enter_init_s ? 8'd0  : rcv_cplh_q;
        rcv_cpld_d   = enter_init_s ? 12'd0 : rcv_cpld_q;
        ovf_d        = ovf_q;
        case ({free_valid_i, free_type_i})
            3'b100: begin
                alloc_ph_d = alloc_ph_d + free_hdr_credit_i;
                alloc_pd_d = alloc_pd_d + free_data_credit_i;
            end
            3'b101: alloc_nph_d = alloc_nph_d + free_hdr_credit_i;
            3'b110: begin
                alloc_cplh_d = alloc_cplh_d + free_hdr_credit_i;
                alloc_cpld_d = alloc_cpld_d + free_data_credit_i;
            end
            default: ;
        endcase
        case ({rx_en_s, rx_tlp_type_i})
            3'b100: begin
                rcv_ph_d = rcv_ph_d + rx_hdr_credit_i;
                rcv_pd_d = rcv_pd_d + rx_data_credit_i;
                ovf_d    = ovf_q | over8(alloc_ph_d, rcv_ph_d) | over12(alloc_pd_d, rcv_pd_d);
            end
            3'b101: begin
                rcv_nph_d = rcv_nph_d + rx_hdr_credit_i;
                ovf_d     = ovf_q | over8(alloc_nph_d, rcv_nph_d);
            end
            3'b110: begin
                rcv_cplh_d = rcv_cplh_d + rx_hdr_credit_i;
                rcv_cpld_d = rcv_cpld_d + rx_data_credit_i;
                ovf_d      = ovf_q | over8(alloc_cplh_d, rcv_cplh_d) | over12(alloc_cpld_d, rcv_cpld_d);
            end
            default: ;
        endcase
        // Launch clears the flag because the fields already carry every free up to the launch edge.
        pend_d = ((enter_init_s ? 3'b000 : pend_q) | free_mask_s | tmr_mask_s) & ~launch_mask_s;
    end

    // State sequencing and DLLP field generation
    always_comb begin
        state_d        = state_q;
        init_req_d     = init_req_q;
        done_d         = done_q;
        dllp_valid_d   = dllp_valid_q;
        dllp_is_init_d = dllp_is_init_q;
        dllp_type_d    = dllp_type_q;
        dllp_hdr_d     = dllp_hdr_q;
        dllp_data_d    = dllp_data_q;
        if (enter_init_s) begin
            state_d        = ST_INIT;
            init_req_d     = 1'b0;
            done_d         = 1'b0;
            dllp_valid_d   = 1'b1;
            dllp_is_init_d = 1'b1;
            dllp_type_d    = T_P;
            dllp_hdr_d     = alloc_ph_d;
            dllp_data_d    = alloc_pd_d;
        end else if (state_q == ST_INIT) begin
            if (hs_s) begin
                case (dllp_type_q)
                    T_P: begin
                        dllp_type_d = T_NP;
                        dllp_hdr_d  = alloc_nph_d;
                        dllp_data_d = 12'd0;
                    end
                    T_NP: begin
                        dllp_type_d = T_CPL;
                        dllp_hdr_d  = alloc_cplh_d;
                        dllp_data_d = alloc_cpld_d;
                    end
                    default: begin
                        dllp_valid_d = 1'b0;
                        state_d      = ST_RUN;
                        done_d       = 1'b1;
                    end
                endcase
            end else begin
                dllp_valid_d = dllp_valid_q;
            end
        end else if (state_q == ST_RUN) begin
            init_req_d = init_req_q | init_fc_start_i;
            if (launch_s) begin
                dllp_valid_d   = 1'b1;
                dllp_is_init_d = 1'b0;
                dllp_type_d    = launch_type_s;
                case (launch_type_s)
                    T_P: begin
                        dllp_hdr_d  = alloc_ph_d;
                        dllp_data_d = alloc_pd_d;
                    end
                    T_NP: begin
                        dllp_hdr_d  = alloc_nph_d;
                        dllp_data_d = 12'd0;
                    end
                    default: begin
                        dllp_hdr_d  = alloc_cplh_d;
                        dllp_data_d = alloc_cpld_d;
                    end
                endcase
            end else if (hs_s) begin
                dllp_valid_d = 1'b0;
            end else begin
                dllp_valid_d = dllp_valid_q;
            end
        end else begin
            state_d = ST_IDLE;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            alloc_ph_q     <= 8'd0;
            alloc_pd_q     <= 12'd0;
            alloc_nph_q    <= 8'd0;
            alloc_cplh_q   <= 8'd0;
            alloc_cpld_q   <= 12'd0;
            rcv_ph_q       <= 8'd0;
            rcv_pd_q       <= 12'd0;
            rcv_nph_q      <= 8'd0;
            rcv_cplh_q     <= 8'd0;
            rcv_cpld_q     <= 12'd0;
            pend_q         <= 3'b000;
            init_req_q     <= 1'b0;
            dllp_valid_q   <= 1'b0;
            dllp_is_init_q <= 1'b0;
            dllp_type_q    <= 2'd0;
            dllp_hdr_q     <= 8'd0;
            dllp_data_q    <= 12'd0;
            done_q         <= 1'b0;
            ovf_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            alloc_ph_q     <= alloc_ph_d;
            alloc_pd_q     <= alloc_pd_d;
            alloc_nph_q    <= alloc_nph_d;
            alloc_cplh_q   <= alloc_cplh_d;
            alloc_cpld_q   <= alloc_cpld_d;
            rcv_ph_q       <= rcv_ph_d;
            rcv_pd_q       <= rcv_pd_d;
            rcv_nph_q      <= rcv_nph_d;
            rcv_cplh_q     <= rcv_cplh_d;
            rcv_cpld_q     <= rcv_cpld_d;
            pend_q         <= pend_d;
            init_req_q     <= init_req_d;
            dllp_valid_q   <= dllp_valid_d;
            dllp_is_init_q <= dllp_is_init_d;
            dllp_type_q    <= dllp_type_d;
            dllp_hdr_q     <= dllp_hdr_d;
            dllp_data_q    <= dllp_data_d;
            done_q         <= done_d;
            ovf_q          <= ovf_d;
        end
    end

    assign dllp_valid_o   = dllp_valid_q;
    assign dllp_is_init_o = dllp_is_init_q;
    assign dllp_fc_type_o = dllp_type_q;
    assign dllp_hdr_fc_o  = dllp_hdr_q;
    assign dllp_data_fc_o = dllp_data_q;
    assign fc_init_done_o = done_q;
    assign overflow_err_o = ovf_q;
endmodule

// File: tb/tb_fc_rx_credit_allocator.sv
// Directed bench for fc_rx_credit_allocator; a second instance with INIT_PD=4000 shows data wrap.
module tb_fc_rx_credit_allocator;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_fc_start_i = 1'b0;
    logic        rx_tlp_valid_i = 1'b0;
    logic [1:0]  rx_tlp_type_i = 2'd0;
    logic [7:0]  rx_hdr_credit_i = 8'd0;
    logic [11:0] rx_data_credit_i = 12'd0;
    logic        free_valid_i = 1'b0;
    logic [1:0]  free_type_i = 2'd0;
    logic [7:0]  free_hdr_credit_i = 8'd0;
    logic [11:0] free_data_credit_i = 12'd0;
    logic        dllp_ready_i = 1'b1;
    logic        dllp_valid_o, dllp_is_init_o, fc_init_done_o, overflow_err_o;
    logic [1:0]  dllp_fc_type_o;
    logic [7:0]  dllp_hdr_fc_o;
    logic [11:0] dllp_data_fc_o;
    logic        v2, ii2, done2, ovf2;
    logic [1:0]  t2;
    logic [7:0]  h2;
    logic [11:0] d2;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    fc_rx_credit_allocator u_dut (
        .clk(clk), .rst_n(rst_n), .init_fc_start_i(init_fc_start_i),
        .rx_tlp_valid_i(rx_tlp_valid_i), .rx_tlp_type_i(rx_tlp_type_i),
        .rx_hdr_credit_i(rx_hdr_credit_i), .rx_data_credit_i(rx_data_credit_i),
        .free_valid_i(free_valid_i), .free_type_i(free_type_i),
        .free_hdr_credit_i(free_hdr_credit_i), .free_data_credit_i(free_data_credit_i),
        .dllp_valid_o(dllp_valid_o), .dllp_ready_i(dllp_ready_i), .dllp_is_init_o(dllp_is_init_o),
        .dllp_fc_type_o(dllp_fc_type_o), .dllp_hdr_fc_o(dllp_hdr_fc_o), .dllp_data_fc_o(dllp_data_fc_o),
        .fc_init_done_o(fc_init_done_o), .overflow_err_o(overflow_err_o)
    );

    fc_rx_credit_allocator #(.INIT_PD(4000)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .init_fc_start_i(init_fc_start_i),
        .rx_tlp_valid_i(rx_tlp_valid_i), .rx_tlp_type_i(rx_tlp_type_i),
        .rx_hdr_credit_i(rx_hdr_credit_i), .rx_data_credit_i(rx_data_credit_i),
        .free_valid_i(free_valid_i), .free_type_i(free_type_i),
        .free_hdr_credit_i(free_hdr_credit_i), .free_data_credit_i(free_data_credit_i),
        .dllp_valid_o(v2), .dllp_ready_i(dllp_ready_i), .dllp_is_init_o(ii2),
        .dllp_fc_type_o(t2), .dllp_hdr_fc_o(h2), .dllp_data_fc_o(d2),
        .fc_init_done_o(done2), .overflow_err_o(ovf2)
    );

    typedef struct {
        logic        start, fv;
        logic [1:0]  ft;
        logic [7:0]  fh;
        logic [11:0] fd;
        logic        rdy;
        logic        ev, ei;
        logic [1:0]  et;
        logic [7:0]  eh;
        logic [11:0] ed, ed2;
        logic        edone;
    } vec_t;

    vec_t tbl [24];

    function automatic vec_t mk(input logic start, input logic fv, input logic [1:0] ft,
                                input logic [7:0] fh, input logic [11:0] fd, input logic rdy,
                                input logic ev, input logic ei, input logic [1:0] et,
                                input logic [7:0] eh, input logic [11:0] ed, input logic [11:0] ed2,
                                input logic edone);
        vec_t v;
        v.start = start; v.fv = fv; v.ft = ft; v.fh = fh; v.fd = fd; v.rdy = rdy;
        v.ev = ev; v.ei = ei; v.et = et; v.eh = eh; v.ed = ed; v.ed2 = ed2; v.edone = edone;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int cnt;
        // Inputs apply before an edge; expectations are the registered outputs just after it.
        // Second instance data: 4000 + 4 + 4 + 4 = 4012, then + 200 wraps to 116.
        tbl[0]  = mk(1'b1, 1'b0, 2'd0, 8'd0, 12'd0,   1'b1, 1'b1, 1'b1, 2'd0, 8'd32, 12'd256, 12'd4000, 1'b0);
        tbl[1]  = mk(1'b0, 1'b0, 2'd0, 8'd0, 12'd0,   1'b1, 1'b1, 1'b1, 2'd1, 8'd32, 12'd0,   12'd0,    1'b0);
        tbl[2]  = mk(1'b0, 1'b0, 2'd0, 8'd0, 12'd0,   1'b1, 1'b1, 1'b1, 2'd2, 8'd64, 12'd512, 12'd512,  1'b0);
        tbl[3]  = mk(1'b0, 1'b0, 2'd0, 8'd0, 12'd0,   1'b1, 1'b0, 1'b0, 2'd0, 8'd0,  12'd0,   12'd0,    1'b1);
        tbl[4]  = mk(1'b0, 1'b1, 2'd0, 8'd1, 12'd4,   1'b1, 1'b0, 1'b0, 2'd0, 8'd0,  12'd0,   12'd0,    1'b1);
        tbl[5]  = mk(1'b0, 1'b0, 2'd0, 8'd0, 12'd0,   1'b1, 1'b1, 1'b0, 2'd0, 8'd33, 12'd260, 12'd4004, 1'b1);
        tbl[6]  = mk(1'b0, 1'b1, 2'd0, 8'd1, 12'd4,   1'b0, 1'b1, 1'b0, 2'd0, 8'd33, 12'd260, 12'd4004, 1'b1);
        tbl[7]  = mk(1'b0, 1'b0, 2'd0, 8'd0, 12'd0,   1'b0, 1'b1, 1'b0, 2'd0, 8'd33, 12'd260, 12'd4004, 1'b1);
        tbl[8]  = mk(1'b0, 1'b0, 2'd0, 8'd0, 12'd0,   1'b0, 1'b1, 1'b0, 2'd0, 8'd33, 12'd260, 12'd4004, 1'b1);
        tbl[9]  = mk(1'b0, 1'b0, 2'd0, 8'd0, 12'd0,   1'b0, 1'b1, 1'b0, 2'd0, 8'd33, 12'd260, 12'd4004, 1'b1);
        tbl[10] = mk(1'b0, 1'b0, 2'd0, 8'd0, 12'd0,   1'b0, 1'b1, 1'b0, 2'd0, 8'd33, 12'd260, 12'd4004, 1'b1);
        tbl[11] = mk(1'b0, 1'b0, 2'd0, 8'd0, 12'd0,   1'b1, 1'b1, 1'b0, 2'd0, 8'd34, 12'd264, 12'd4008, 1'b1);
        tbl[12] = mk(1'b0, 1'b0, 2'd0, 8'd0, 12'd0,   1'b1, 1'b0, 1'b0, 2'd0, 8'd0,  12'd0,   12'd0,    1'b1);
        tbl[13] = mk(1'b0, 1'b1, 2'd2, 8'd2, 12'd8,   1'b1, 1'b0, 1'b0, 2'd0, 8'd0,  12'd0,   12'd0,    1'b1);
        tbl[14] = mk(1'b0, 1'b1, 2'd1, 8'd3, 12'd0,   1'b1, 1'b1, 1'b0, 2'd2, 8'd66, 12'd520, 12'd520,  1'b1);
        tbl[15] = mk(1'b0, 1'b1, 2'd0, 8'd1, 12'd4,   1'b0, 1'b1, 1'b0, 2'd2, 8'd66, 12'd520, 12'd520,  1'b1);
        tbl[16] = mk(1'b0, 1'b0, 2'd0, 8'd0, 12'd0,   1'b1, 1'b1, 1'b0, 2'd0, 8'd35, 12'd268, 12'd4012, 1'b1);
        tbl[17] = mk(1'b0, 1'b0, 2'd0, 8'd0, 12'd0,   1'b1, 1'b1, 1'b0, 2'd1, 8'd35, 12'd0,   12'd0,    1'b1);
        tbl[18] = mk(1'b0, 1'b0, 2'd0, 8'd0, 12'd0,   1'b1, 1'b0, 1'b0, 2'd0, 8'd0,  12'd0,   12'd0,    1'b1);
        tbl[19] = mk(1'b0, 1'b1, 2'd0, 8'd0, 12'd200, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0,  12'd0,   12'd0,    1'b1);
        tbl[20] = mk(1'b0, 1'b0, 2'd0, 8'd0, 12'd0,   1'b1, 1'b1, 1'b0, 2'd0, 8'd35, 12'd468, 12'd116,  1'b1);
        tbl[21] = mk(1'b0, 1'b1, 2'd0, 8'd1, 12'd0,   1'b1, 1'b0, 1'b0, 2'd0, 8'd0,  12'd0,   12'd0,    1'b1);
        tbl[22] = mk(1'b0, 1'b0, 2'd0, 8'd0, 12'd0,   1'b1, 1'b1, 1'b0, 2'd0, 8'd36, 12'd468, 12'd116,  1'b1);
        tbl[23] = mk(1'b0, 1'b0, 2'd0, 8'd0, 12'd0,   1'b1, 1'b0, 1'b0, 2'd0, 8'd0,  12'd0,   12'd0,    1'b1);

        repeat (2) @(posedge clk);
        #1;
        chk("reset valid", {31'd0, dllp_valid_o}, 32'd0);
        chk("reset fields", {9'd0, dllp_is_init_o, dllp_fc_type_o, dllp_hdr_fc_o, dllp_data_fc_o}, 32'd0);
        chk("reset done/ovf", {30'd0, fc_init_done_o, overflow_err_o}, 32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        chk("idle no dllp", {31'd0, dllp_valid_o}, 32'd0);

        for (int i = 0; i < 24; i++) begin
            init_fc_start_i    = tbl[i].start;
            free_valid_i       = tbl[i].fv;
            free_type_i        = tbl[i].ft;
            free_hdr_credit_i  = tbl[i].fh;
            free_data_credit_i = tbl[i].fd;
            dllp_ready_i       = tbl[i].rdy;
            tick();
            chk($sformatf("row%0d valid", i), {31'd0, dllp_valid_o}, {31'd0, tbl[i].ev});
            chk($sformatf("row%0d done", i), {31'd0, fc_init_done_o}, {31'd0, tbl[i].edone});
            if (tbl[i].ev) begin
                chk($sformatf("row%0d fields", i),
                    {9'd0, dllp_is_init_o, dllp_fc_type_o, dllp_hdr_fc_o, dllp_data_fc_o},
                    {9'd0, tbl[i].ei, tbl[i].et, tbl[i].eh, tbl[i].ed});
                chk($sformatf("row%0d data2", i), {20'd0, d2}, {20'd0, tbl[i].ed2});
            end
        end
        free_valid_i = 1'b0;
        init_fc_start_i = 1'b0;

        // Re-init requested twice while an UpdateFC is stalled: applied once, after the handshake.
        free_valid_i = 1'b1; free_type_i = 2'd0; free_hdr_credit_i = 8'd1; free_data_credit_i = 12'd0;
        dllp_ready_i = 1'b0;
        tick();
        free_valid_i = 1'b0;
        tick();
        chk("stall update", {22'd0, dllp_valid_o, dllp_is_init_o, dllp_hdr_fc_o}, {22'd0, 1'b1, 1'b0, 8'd37});
        init_fc_start_i = 1'b1; tick();
        init_fc_start_i = 1'b0; tick();
        init_fc_start_i = 1'b1; tick();
        init_fc_start_i = 1'b0;
        chk("stall held", {22'd0, dllp_valid_o, dllp_is_init_o, dllp_hdr_fc_o}, {22'd0, 1'b1, 1'b0, 8'd37});
        dllp_ready_i = 1'b1;
        tick();
        chk("reinit P", {8'd0, dllp_valid_o, dllp_is_init_o, dllp_fc_type_o, dllp_hdr_fc_o, dllp_data_fc_o},
            {8'd0, 1'b1, 1'b1, 2'd0, 8'd32, 12'd256});
        chk("reinit done low", {31'd0, fc_init_done_o}, 32'd0);
        tick();
        tick();
        tick();
        chk("reinit done", {30'd0, fc_init_done_o, dllp_valid_o}, {30'd0, 1'b1, 1'b0});
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (dllp_valid_o) cnt++;
        end
        chk("single reinit", cnt, 32'd0);

        // Overflow: type 11 ignored, 32 P headers fit, the 33rd overflows and the flag sticks.
        rx_tlp_valid_i = 1'b1; rx_tlp_type_i = 2'd3; rx_hdr_credit_i = 8'd200; rx_data_credit_i = 12'd0;
        tick();
        chk("rx type3 ignored", {31'd0, overflow_err_o}, 32'd0);
        rx_tlp_type_i = 2'd0; rx_hdr_credit_i = 8'd1;
        for (int i = 0; i < 32; i++) tick();
        rx_tlp_valid_i = 1'b0;
        chk("ovf after 32", {31'd0, overflow_err_o}, 32'd0);
        rx_tlp_valid_i = 1'b1;
        tick();
        rx_tlp_valid_i = 1'b0;
        chk("ovf after 33", {31'd0, overflow_err_o}, 32'd1);
        repeat (5) tick();
        chk("ovf sticky", {31'd0, overflow_err_o}, 32'd1);

`ifndef FC_UPDATE_TIMER_EN
        cnt = 0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (dllp_valid_o) cnt++;
        end
        chk("no timer dllps", cnt, 32'd0);
`endif

        // Asynchronous reset while a DLLP is stalled drops everything without a clock edge.
        free_valid_i = 1'b1; free_type_i = 2'd1; free_hdr_credit_i = 8'd1;
        dllp_ready_i = 1'b0;
        tick();
        free_valid_i = 1'b0;
        tick();
        chk("pre-reset valid", {31'd0, dllp_valid_o}, 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async rst valid", {31'd0, dllp_valid_o}, 32'd0);
        chk("async rst flags", {30'd0, fc_init_done_o, overflow_err_o}, 32'd0);
        tick();
        chk("rst held", {9'd0, dllp_is_init_o, dllp_fc_type_o, dllp_hdr_fc_o, dllp_data_fc_o}, 32'd0);
        rst_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
